alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 114 +++++++++++
 tb/tb_alu_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: 4x8 register file sequencing an external ALU over IDLE/EXEC/DRIVE; ALU_SEQ_QUEUE_EN adds a one-entry pending command
module alu_sequencer (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [1:0] i_op,
  input  logic       i_sub,
  input  logic [1:0] i_srcA,
  input  logic [1:0] i_srcB,
  input  logic [1:0] i_dst,
  input  logic       i_wrEn,
  input  logic [1:0] i_wrAddr,
  input  logic [7:0] i_wrData,
  input  logic [1:0] i_rdAddr,
  output logic [7:0] o_rdData,
  output logic [7:0] o_a,
  output logic [7:0] o_b,
  output logic [1:0] o_aluOp,
  output logic       o_subShiftDir,
  output logic       o_aluWr,
  output logic       o_noe,
  input  logic [7:0] i_bus,
  input  logic       i_negative,
  input  logic       i_nZero,
  output logic       o_flagN,
  output logic       o_flagNZ,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_done
);
  typedef enum logic [1:0] {IDLE, EXEC, DRIVE} state_t;
  state_t state;
  logic [7:0] regs [4];
  logic [1:0] dst, l_op, l_a, l_b, l_dst;
  logic l_sub, go;
  assign o_rdData = regs[i_rdAddr];
`ifdef ALU_SEQ_QUEUE_EN
  logic p_v, p_sub;
  logic [1:0] p_op, p_a, p_b, p_dst;
  assign o_ready = ~p_v;
  assign go = state == IDLE && (p_v || i_start);
  always_comb begin
    l_op = p_v ? p_op : i_op;
    l_sub = p_v ? p_sub : i_sub;
    l_a = p_v ? p_a : i_srcA;
    l_b = p_v ? p_b : i_srcB;
    l_dst = p_v ? p_dst : i_dst;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      p_v <= 1'b0;
      p_op <= 2'd0;
      p_sub <= 1'b0;
      p_a <= 2'd0;
      p_b <= 2'd0;
      p_dst <= 2'd0;
    end else if (p_v) begin
      p_v <= state != IDLE;
    end else if (i_start && state != IDLE) begin
      p_v <= 1'b1;
      p_op <= i_op;
      p_sub <= i_sub;
      p_a <= i_srcA;
      p_b <= i_srcB;
      p_dst <= i_dst;
    end
  end
`else
  assign o_ready = ~o_busy;
  assign go = state == IDLE && i_start;
  assign l_op = i_op;
  assign l_sub = i_sub;
  assign l_a = i_srcA;
  assign l_b = i_srcB;
  assign l_dst = i_dst;
`endif
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      for (int i = 0; i < 4; i++) regs[i] <= 8'd0;
      o_a <= 8'd0;
      o_b <= 8'd0;
      o_aluOp <= 2'd0;
      o_subShiftDir <= 1'b0;
      dst <= 2'd0;
      o_aluWr <= 1'b0;
      o_noe <= 1'b1;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_flagN <= 1'b0;
      o_flagNZ <= 1'b0;
    end else begin
      state <= go ? EXEC : state == EXEC ? DRIVE : IDLE;
      o_aluWr <= go;
      o_noe <= state != EXEC;
      o_busy <= go || state == EXEC;
      o_done <= state == DRIVE;
      for (int i = 0; i < 4; i++)
        if (state == DRIVE && dst == 2'(i)) regs[i] <= i_bus;
        else if (i_wrEn && i_wrAddr == 2'(i)) regs[i] <= i_wrData;
      if (state == DRIVE) begin
        o_flagN <= i_negative;
        o_flagNZ <= i_nZero;
      end
      if (go) begin
        o_a <= regs[l_a];
        o_b <= regs[l_b];
        o_aluOp <= l_op;
        o_subShiftDir <= l_sub;
        dst <= l_dst;
      end
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized scenarios checked against a register-file/flag model of the sequencer
module tb_alu_sequencer;
  logic i_clk = 1'b0, i_reset = 1'b1, i_start = 1'b0, i_sub = 1'b0, i_wrEn = 1'b0;
  logic i_negative = 1'b0, i_nZero = 1'b0;
  logic [1:0] i_op = 2'd0, i_srcA = 2'd0, i_srcB = 2'd0, i_dst = 2'd0, i_wrAddr = 2'd0, i_rdAddr = 2'd0;
  logic [7:0] i_wrData = 8'd0, i_bus = 8'd0;
  logic [7:0] o_rdData, o_a, o_b;
  logic [1:0] o_aluOp;
  logic o_subShiftDir, o_aluWr, o_noe, o_flagN, o_flagNZ, o_ready, o_busy, o_done;
  int n_chk = 0, n_fail = 0;
  logic [7:0] m [4];
  logic f_n = 1'b0, f_nz = 1'b0;
`ifdef ALU_SEQ_QUEUE_EN
  localparam logic QR = 1'b1;
`else
  localparam logic QR = 1'b0;
`endif

  alu_sequencer dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_op(i_op), .i_sub(i_sub),
    .i_srcA(i_srcA), .i_srcB(i_srcB), .i_dst(i_dst), .i_wrEn(i_wrEn), .i_wrAddr(i_wrAddr),
    .i_wrData(i_wrData), .i_rdAddr(i_rdAddr), .o_rdData(o_rdData), .o_a(o_a), .o_b(o_b),
    .o_aluOp(o_aluOp), .o_subShiftDir(o_subShiftDir), .o_aluWr(o_aluWr), .o_noe(o_noe),
    .i_bus(i_bus), .i_negative(i_negative), .i_nZero(i_nZero), .o_flagN(o_flagN),
    .o_flagNZ(o_flagNZ), .o_ready(o_ready), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    i_wrEn = 1'b1;
    i_wrAddr = a;
    i_wrData = d;
    step();
    i_wrEn = 1'b0;
    m[a] = d;
  endtask

  task automatic test_reset;
    i_reset = 1'b1;
    i_start = 1'b1;
    step();
    step();
    i_start = 1'b0;
    for (int i = 0; i < 4; i++) m[i] = 8'd0;
    f_n = 1'b0;
    f_nz = 1'b0;
    n_chk++;
    if ({o_ready, o_busy, o_done, o_noe, o_aluWr, o_flagN, o_flagNZ} !== 7'b1001000) begin
      n_fail++;
      $display("FAIL reset_status got %b want 1001000", {o_ready, o_busy, o_done, o_noe, o_aluWr, o_flagN, o_flagNZ});
    end
    n_chk++;
    if ({o_a, o_b, o_aluOp, o_subShiftDir} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_cmd got a=%h b=%h op=%b sub=%b want zeros", o_a, o_b, o_aluOp, o_subShiftDir);
    end
    for (int i = 0; i < 4; i++) begin
      i_rdAddr = 2'(i);
      #1;
      n_chk++;
      if (o_rdData !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_reg R%0d got %h want 00", i, o_rdData);
      end
    end
    i_reset = 1'b0;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic sub, input logic [1:0] sa, sb, d,
                        input logic [7:0] bus, input logic neg, nz,
                        input logic ext, input logic [1:0] ea, input logic [7:0] ed,
                        input logic hold, input logic clob);
    logic [7:0] va, vb, cd;
    va = m[sa];
    vb = m[sb];
    cd = 8'($urandom);
    i_start = 1'b1;
    i_op = op;
    i_sub = sub;
    i_srcA = sa;
    i_srcB = sb;
    i_dst = d;
    step();
    i_start = hold;
    i_op = 2'($urandom);
    i_sub = 1'($urandom);
    i_srcA = 2'($urandom);
    i_srcB = 2'($urandom);
    i_dst = 2'($urandom);
    n_chk++;
    if ({o_aluWr, o_noe, o_busy, o_ready, o_done} !== {3'b111, QR, 1'b0}) begin
      n_fail++;
      $display("FAIL exec_status got %b want %b", {o_aluWr, o_noe, o_busy, o_ready, o_done}, {3'b111, QR, 1'b0});
    end
    n_chk++;
    if ({o_a, o_b, o_aluOp, o_subShiftDir} !== {va, vb, op, sub}) begin
      n_fail++;
      $display("FAIL exec_operands got %h %h %b %b want %h %h %b %b", o_a, o_b, o_aluOp, o_subShiftDir, va, vb, op, sub);
    end
    if (clob) begin
      i_wrEn = 1'b1;
      i_wrAddr = sa;
      i_wrData = cd;
    end
    step();
    if (clob) m[sa] = cd;
    i_wrEn = 1'b0;
    n_chk++;
    if ({o_aluWr, o_noe, o_busy, o_ready, o_done} !== {3'b001, QR, 1'b0}) begin
      n_fail++;
      $display("FAIL drive_status got %b want %b", {o_aluWr, o_noe, o_busy, o_ready, o_done}, {3'b001, QR, 1'b0});
    end
    n_chk++;
    if ({o_a, o_b, o_aluOp, o_subShiftDir} !== {va, vb, op, sub}) begin
      n_fail++;
      $display("FAIL drive_operands got %h %h %b %b want %h %h %b %b", o_a, o_b, o_aluOp, o_subShiftDir, va, vb, op, sub);
    end
    i_bus = bus;
    i_negative = neg;
    i_nZero = nz;
    i_wrEn = ext;
    i_wrAddr = ea;
    i_wrData = ed;
    step();
    i_start = 1'b0;
    i_wrEn = 1'b0;
    i_bus = 8'($urandom);
    i_negative = 1'($urandom);
    i_nZero = 1'($urandom);
    if (ext) m[ea] = ed;
    m[d] = bus;
    f_n = neg;
    f_nz = nz;
    n_chk++;
    if ({o_aluWr, o_noe, o_busy, o_ready, o_done, o_flagN, o_flagNZ} !== {5'b01011, f_n, f_nz}) begin
      n_fail++;
      $display("FAIL done_status got %b want %b", {o_aluWr, o_noe, o_busy, o_ready, o_done, o_flagN, o_flagNZ}, {5'b01011, f_n, f_nz});
    end
    for (int i = 0; i < 4; i++) begin
      i_rdAddr = 2'(i);
      #1;
      n_chk++;
      if (o_rdData !== m[i]) begin
        n_fail++;
        $display("FAIL regfile R%0d got %h want %h", i, o_rdData, m[i]);
      end
    end
    step();
    n_chk++;
    if ({o_aluWr, o_noe, o_busy, o_done} !== 4'b0100) begin
      n_fail++;
      $display("FAIL after_done got %b want 0100", {o_aluWr, o_noe, o_busy, o_done});
    end
  endtask

  task automatic test_add;
    wr(2'd1, 8'h05);
    wr(2'd2, 8'h03);
    do_cmd(2'b00, 1'b0, 2'd1, 2'd2, 2'd3, 8'h08, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_busy_ignore;
    do_cmd(2'b01, 1'b0, 2'd3, 2'd1, 2'd0, 8'h41, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_wb_priority;
    do_cmd(2'b00, 1'b0, 2'd1, 2'd2, 2'd3, 8'h08, 1'b0, 1'b1, 1'b1, 2'd3, 8'hFF, 1'b0, 1'b0);
    do_cmd(2'b00, 1'b0, 2'd1, 2'd2, 2'd3, 8'h08, 1'b0, 1'b1, 1'b1, 2'd0, 8'hFF, 1'b0, 1'b0);
  endtask

  task automatic test_flags;
    do_cmd(2'b10, 1'b0, 2'd0, 2'd2, 2'd1, 8'h80, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    do_cmd(2'b10, 1'b0, 2'd1, 2'd1, 2'd2, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    do_cmd(2'b11, 1'b1, 2'd2, 2'd2, 2'd2, 8'h5A, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid;
    i_start = 1'b1;
    i_srcA = 2'd1;
    i_srcB = 2'd3;
    i_dst = 2'd2;
    step();
    i_start = 1'b0;
    step();
    i_reset = 1'b1;
    i_bus = 8'hAA;
    step();
    for (int i = 0; i < 4; i++) m[i] = 8'd0;
    f_n = 1'b0;
    f_nz = 1'b0;
    n_chk++;
    if ({o_noe, o_done, o_busy, o_aluWr, o_ready, o_flagN, o_flagNZ} !== 7'b1000100) begin
      n_fail++;
      $display("FAIL reset_mid_status got %b want 1000100", {o_noe, o_done, o_busy, o_aluWr, o_ready, o_flagN, o_flagNZ});
    end
    for (int i = 0; i < 4; i++) begin
      i_rdAddr = 2'(i);
      #1;
      n_chk++;
      if (o_rdData !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_mid_reg R%0d got %h want 00", i, o_rdData);
      end
    end
    i_reset = 1'b0;
    step();
    n_chk++;
    if ({o_done, o_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid_nodone got %b want 00", {o_done, o_busy});
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 24; k++)
      do_cmd(2'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom), 1'b0, 1'($urandom));
  endtask

`ifdef ALU_SEQ_QUEUE_EN
  task automatic test_queue;
    wr(2'd1, 8'h05);
    wr(2'd2, 8'h03);
    i_start = 1'b1;
    i_op = 2'b00;
    i_sub = 1'b0;
    i_srcA = 2'd1;
    i_srcB = 2'd2;
    i_dst = 2'd3;
    step();
    i_srcA = 2'd3;
    i_srcB = 2'd1;
    step();
    i_start = 1'b0;
    n_chk++;
    if ({o_ready, o_noe} !== 2'b00) begin
      n_fail++;
      $display("FAIL queue_full got %b want 00", {o_ready, o_noe});
    end
    i_bus = 8'h08;
    i_negative = 1'b0;
    i_nZero = 1'b1;
    step();
    i_rdAddr = 2'd3;
    #1;
    n_chk++;
    if ({o_done, o_rdData} !== {1'b1, 8'h08}) begin
      n_fail++;
      $display("FAIL queue_first got %b %h want 1 08", o_done, o_rdData);
    end
    step();
    n_chk++;
    if ({o_aluWr, o_done, o_a, o_b} !== {2'b10, 8'h08, 8'h05}) begin
      n_fail++;
      $display("FAIL queue_second_exec got %b %b %h %h want 1 0 08 05", o_aluWr, o_done, o_a, o_b);
    end
    step();
    i_bus = 8'h0D;
    step();
    i_rdAddr = 2'd3;
    #1;
    m[3] = 8'h0D;
    n_chk++;
    if ({o_done, o_rdData} !== {1'b1, 8'h0D}) begin
      n_fail++;
      $display("FAIL queue_second got %b %h want 1 0d", o_done, o_rdData);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_add();
`ifndef ALU_SEQ_QUEUE_EN
    test_busy_ignore();
`endif
    test_wb_priority();
    test_flags();
    test_random();
    test_reset_mid();
`ifdef ALU_SEQ_QUEUE_EN
    test_queue();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
